fwd_hazard_unit: RTL

Forwarding and hazard controller for the 5-stage MIPS pipeline. It produces the 2-bit channel selects consumed by the two 3-to-1 ALU-operand multiplexers in EX, and raises a load-use stall. It tracks the destination registers of the instructions in EX and MEM with its own shadow pipeline, sits beside the ID/EX register, and is clocked with the datapath.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/fwd_hazard_unit_if.sv | 27 ++
 rtl/fwd_src_sel.sv | 27 ++
 rtl/fwd_hazard_unit.sv | 111 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS forwarding/hazard logic: mux-select encodings,
// the shadow-pipeline entry, its bubble value and the entry-match helper.
package mips_pkg;

    localparam int HAZ_DST_W = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_read;
        logic [HAZ_DST_W-1:0] dst;
    } haz_entry_t;

    localparam haz_entry_t HAZ_BUBBLE = '0;

    // $0 is hard-wired, so a write to it never produces a value worth forwarding
    function automatic logic haz_match(input haz_entry_t e, input logic [HAZ_DST_W-1:0] src);
        return e.valid && e.reg_write && (e.dst != '0) && (e.dst == src);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-side request and EX-side select/stall bundle of the forwarding and hazard unit.
interface fwd_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_dst;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_dst, id_reg_write, id_mem_read, flush,
        input  fwd_a, fwd_b, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_dst, id_reg_write, id_mem_read, flush,
        output fwd_a, fwd_b, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_src_sel.sv
// Per-source forwarding select: compares one ID source index with the EX and MEM
// shadow entries; the youngest (EX) writer wins when both hold the same register.
module fwd_src_sel
    import mips_pkg::*;
(
    input  logic [HAZ_DST_W-1:0] src,
    input  haz_entry_t           ex,
    input  haz_entry_t           mem,
    output logic [1:0]           sel,
    output logic                 ex_load_match
);
    logic hit_ex;
    logic hit_mem;

    always_comb begin
        hit_ex        = haz_match(ex, src);
        hit_mem       = haz_match(mem, src);
        ex_load_match = hit_ex & ex.mem_read;
        if (hit_ex) begin
            sel = FWD_EXMEM;
        end else if (hit_mem) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller beside the ID/EX register.
// Define HAZ_FORWARD_EN for forwarding; otherwise every RAW dependency stalls.
module fwd_hazard_unit
    import mips_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst,
    fwd_hazard_unit_if.slave bus
);
    haz_entry_t        ex;
    haz_entry_t        mem;
    haz_entry_t        id_entry;
    logic [REG_AW-1:0] src_a;
    logic [REG_AW-1:0] src_b;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic              ld_a;
    logic              ld_b;
    logic              stall_c;
    logic              advance;
    logic [CNT_W-1:0]  cnt_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign src_a = bus.id_rs;
    assign src_b = bus.id_rt;

    fwd_src_sel u_sel_a (
        .src           (src_a),
        .ex            (ex),
        .mem           (mem),
        .sel           (sel_a),
        .ex_load_match (ld_a)
    );

    fwd_src_sel u_sel_b (
        .src           (src_b),
        .ex            (ex),
        .mem           (mem),
        .sel           (sel_b),
        .ex_load_match (ld_b)
    );

`ifdef HAZ_FORWARD_EN
    // rt is checked even for instructions that never read it; the spare stall is harmless
    assign stall_c = bus.id_valid & ~bus.flush & (ld_a | ld_b);
`else
    assign stall_c = bus.id_valid & ~bus.flush & ((sel_a != FWD_RF) | (sel_b != FWD_RF));
`endif

    assign advance = bus.id_valid & ~bus.flush & ~stall_c;

    always_comb begin
        id_entry           = HAZ_BUBBLE;
        id_entry.valid     = bus.id_valid;
        id_entry.reg_write = bus.id_reg_write;
        id_entry.mem_read  = bus.id_mem_read;
        id_entry.dst       = bus.id_dst;
    end

    // ID -> EX -> MEM shadow of destination registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex  <= HAZ_BUBBLE;
            mem <= HAZ_BUBBLE;
        end else begin
            mem <= ex;
            ex  <= advance ? id_entry : HAZ_BUBBLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p0 <= '0;
        end else if (stall_c) begin
            cnt_p0 <= sat_inc(cnt_p0);
        end
    end

`ifdef HAZ_FORWARD_EN
    logic [1:0] fwd_a_p0;
    logic [1:0] fwd_b_p0;

    // ID -> EX: select registered so it is stable while the instruction sits in EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_a_p0 <= FWD_RF;
            fwd_b_p0 <= FWD_RF;
        end else begin
            fwd_a_p0 <= advance ? sel_a : FWD_RF;
            fwd_b_p0 <= advance ? sel_b : FWD_RF;
        end
    end

    assign bus.fwd_a = fwd_a_p0;
    assign bus.fwd_b = fwd_b_p0;
`else
    logic unused_ld;
    assign unused_ld = ld_a | ld_b;
    assign bus.fwd_a = FWD_RF;
    assign bus.fwd_b = FWD_RF;
`endif

    assign bus.stall     = stall_c;
    assign bus.stall_cnt = cnt_p0;
endmodule
